// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush sequencer (PIPE_CTRL_PERF_EN adds perf_stall/perf_flush counters)
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_memR,
  input  logic [4:0] idex_gprDes,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_useRt,
  input  logic       branch_taken,
  input  logic       exmem_memR,
  input  logic       exmem_memW,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       exmem_write,
  output logic       memwb_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
  state_t state;
  logic [2:0] stall_cnt;
  logic mem_stall, lu_hazard, eff_ls, flush, bubble;
  always_comb begin
    mem_stall = (exmem_memR | exmem_memW) & !dmem_ready;
    lu_hazard = idex_memR & (idex_gprDes != 5'd0) &
                ((idex_gprDes == ifid_rs) | (ifid_useRt & (idex_gprDes == ifid_rt)));
    eff_ls = (state == LOAD_STALL) | ((state == MEM_WAIT) & (stall_cnt != 3'd0));
    flush = !mem_stall & branch_taken;
    bubble = !mem_stall & !branch_taken & (eff_ls | lu_hazard);
    pc_write = !rst & !mem_stall & !bubble;
    ifid_write = !rst & !mem_stall & !bubble;
    idex_write = !rst & !mem_stall;
    exmem_write = !rst & !mem_stall;
    memwb_write = !rst & !mem_stall;
    ifid_flush = rst | flush;
    idex_flush = rst | flush | bubble;
    exmem_flush = rst | flush;
  end
  assign ctrl_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stall_cnt <= 3'd0;
    end else if (mem_stall) begin
      state <= MEM_WAIT;
    end else if (branch_taken) begin
      state <= RUN;
      stall_cnt <= 3'd0;
    end else if (eff_ls) begin
      stall_cnt <= stall_cnt - 3'd1;
      state <= (stall_cnt == 3'd1) ? RUN : LOAD_STALL;
    end else if (lu_hazard && LOAD_STALL_CYCLES > 1) begin
      stall_cnt <= 3'(LOAD_STALL_CYCLES - 1);
      state <= LOAD_STALL;
    end else begin
      state <= RUN;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= 32'd0;
      perf_flush <= 32'd0;
    end else begin
      perf_stall <= perf_stall + 32'(bubble | mem_stall);
      perf_flush <= perf_flush + 32'(flush);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl with LOAD_STALL_CYCLES=2 and 3
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, idex_memR, ifid_useRt, branch_taken, exmem_memR, exmem_memW, dmem_ready;
  logic [4:0] idex_gprDes, ifid_rs, ifid_rt;
  logic pw2, fw2, dw2, ew2, mw2, ff2, df2, ef2, pw3, fw3, dw3, ew3, mw3, ff3, df3, ef3;
  logic [1:0] st2, st3;
  logic [7:0] o2, o3;
  int checks = 0;
  int errors = 0;
  localparam logic [7:0] NORM = 8'b11111_000;
  localparam logic [7:0] BUB  = 8'b00111_010;
  localparam logic [7:0] FRZ  = 8'b00000_000;
  localparam logic [7:0] FLU  = 8'b11111_111;
  localparam logic [7:0] RST  = 8'b00000_111;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] ps2, pf2, ps3, pf3;
`endif
  always #5 clk = ~clk;
  assign o2 = {pw2, fw2, dw2, ew2, mw2, ff2, df2, ef2};
  assign o3 = {pw3, fw3, dw3, ew3, mw3, ff3, df3, ef3};
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .idex_memR(idex_memR), .idex_gprDes(idex_gprDes),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRt(ifid_useRt),
    .branch_taken(branch_taken), .exmem_memR(exmem_memR), .exmem_memW(exmem_memW),
    .dmem_ready(dmem_ready), .pc_write(pw2), .ifid_write(fw2), .idex_write(dw2),
    .exmem_write(ew2), .memwb_write(mw2), .ifid_flush(ff2), .idex_flush(df2),
    .exmem_flush(ef2), .ctrl_state(st2)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall(ps2), .perf_flush(pf2)
`endif
  );
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .idex_memR(idex_memR), .idex_gprDes(idex_gprDes),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRt(ifid_useRt),
    .branch_taken(branch_taken), .exmem_memR(exmem_memR), .exmem_memW(exmem_memW),
    .dmem_ready(dmem_ready), .pc_write(pw3), .ifid_write(fw3), .idex_write(dw3),
    .exmem_write(ew3), .memwb_write(mw3), .ifid_flush(ff3), .idex_flush(df3),
    .exmem_flush(ef3), .ctrl_state(st3)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall(ps3), .perf_flush(pf3)
`endif
  );
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task idle;
    rst = 1'b0; idex_memR = 1'b0; idex_gprDes = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_useRt = 1'b0; branch_taken = 1'b0; exmem_memR = 1'b0; exmem_memW = 1'b0;
    dmem_ready = 1'b1;
  endtask
  task hazard;
    idex_memR = 1'b1; idex_gprDes = 5'd5; ifid_rs = 5'd5;
  endtask
  task do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk("rst1_o2", 32'(o2), 32'(RST));
    tick();
    chk("rst2_o3", 32'(o3), 32'(RST));
    chk("rst_st2", 32'(st2), 32'd0);
    chk("rst_st3", 32'(st3), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_perf_s", ps3, 32'd0);
    chk("rst_perf_f", pf3, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_o2", 32'(o2), 32'(NORM));
    chk("rel_o3", 32'(o3), 32'(NORM));
    tick();
    hazard();
    #1;
    chk("lu0_o2", 32'(o2), 32'(BUB));
    chk("lu0_o3", 32'(o3), 32'(BUB));
    tick();
    idle();
    #1;
    chk("lu1_o2", 32'(o2), 32'(BUB));
    chk("lu1_st2", 32'(st2), 32'd1);
    chk("lu1_o3", 32'(o3), 32'(BUB));
    tick();
    chk("lu2_o2", 32'(o2), 32'(NORM));
    chk("lu2_o3", 32'(o3), 32'(BUB));
    tick();
    chk("lu3_o3", 32'(o3), 32'(NORM));
    chk("lu3_st3", 32'(st3), 32'd0);
    hazard();
    idex_gprDes = 5'd0; ifid_rs = 5'd0;
    #1;
    chk("r0_o2", 32'(o2), 32'(NORM));
    idex_gprDes = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    #1;
    chk("rt_nouse_o2", 32'(o2), 32'(NORM));
    tick();
    chk("rt_nouse_st2", 32'(st2), 32'd0);
    do_reset();
    hazard();
    branch_taken = 1'b1;
    #1;
    chk("br_o2", 32'(o2), 32'(FLU));
    chk("br_o3", 32'(o3), 32'(FLU));
    tick();
    idle();
    #1;
    chk("br_next_o3", 32'(o3), 32'(NORM));
    chk("br_next_st3", 32'(st3), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("br_perf_f", pf3, 32'd1);
    chk("br_perf_s", ps3, 32'd0);
`endif
    exmem_memR = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw%0d_o2", i), 32'(o2), 32'(FRZ));
      if (i > 0) chk($sformatf("mw%0d_st2", i), 32'(st2), 32'd2);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_rdy_o2", 32'(o2), 32'(NORM));
    chk("mw_rdy_st2", 32'(st2), 32'd2);
    tick();
    idle();
    chk("mw_done_st2", 32'(st2), 32'd0);
    exmem_memW = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    #1;
    chk("mwbr_frz_o3", 32'(o3), 32'(FRZ));
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("mwbr_flu_o3", 32'(o3), 32'(FLU));
    tick();
    idle();
    #1;
    chk("mwbr_after_o3", 32'(o3), 32'(NORM));
    do_reset();
    hazard();
    #1;
    chk("int0_o3", 32'(o3), 32'(BUB));
    tick();
    idle();
    exmem_memR = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("int1_o3", 32'(o3), 32'(FRZ));
    tick();
    chk("int2_o3", 32'(o3), 32'(FRZ));
    chk("int2_st3", 32'(st3), 32'd2);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("int3_o3", 32'(o3), 32'(BUB));
    chk("int3_o2", 32'(o2), 32'(BUB));
    tick();
    idle();
    #1;
    chk("int4_o3", 32'(o3), 32'(BUB));
    chk("int4_o2", 32'(o2), 32'(NORM));
    tick();
    chk("int5_o3", 32'(o3), 32'(NORM));
`ifdef PIPE_CTRL_PERF_EN
    chk("int_perf_s3", ps3, 32'd5);
    chk("int_perf_s2", ps2, 32'd4);
`endif
    hazard();
    tick();
    idle();
    chk("rm_st3", 32'(st3), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_rst_o3", 32'(o3), 32'(RST));
    tick();
    rst = 1'b0;
    #1;
    chk("rm_rel_o3", 32'(o3), 32'(NORM));
    chk("rm_rel_st3", 32'(st3), 32'd0);
    tick();
    chk("rm_next_o3", 32'(o3), 32'(NORM));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
